// File: rtl/arith_pkg.sv
// Shared constants and configuration checks for the arithmetic-logic library adders.
package arith_pkg;

   localparam int ADD_WIDTH     = 32;
   localparam int ADD_SEG_WIDTH = 8;

   // True when WIDTH splits evenly into whole segments.
   function automatic bit seg_cfg_ok(input int width, input int seg_width);
      return (seg_width > 0) && (width >= seg_width) && ((width % seg_width) == 0);
   endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
interface pipelined_adder_if
   import arith_pkg::*;
#(
   parameter int WIDTH = ADD_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carry_in;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
   logic             overflow;

   modport master (
      output in_valid, a, b, carry_in, sub, out_ready,
      input  in_ready, out_valid, sum, carry_out, overflow
   );

   modport slave (
      input  in_valid, a, b, carry_in, sub, out_ready,
      output in_ready, out_valid, sum, carry_out, overflow
   );
endinterface

// File: rtl/seg_adder.sv
// Combinational SEG_WIDTH-bit adder with a flattened carry-lookahead network.
module seg_adder
   import arith_pkg::*;
#(
   parameter int SEG_WIDTH = ADD_SEG_WIDTH
) (
   input  logic [SEG_WIDTH-1:0] a,
   input  logic [SEG_WIDTH-1:0] b,
   input  logic                 cin,
   output logic [SEG_WIDTH-1:0] s,
   output logic                 cout
);
   logic [SEG_WIDTH-1:0] w_g;
   logic [SEG_WIDTH-1:0] w_p;
   logic [SEG_WIDTH:0]   w_c;
   logic                 w_term;
   logic                 w_prop;

   assign w_g = a & b;
   assign w_p = a ^ b;

   // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i:0]cin, each carry as its own sum of products
   always_comb begin
      w_c    = '0;
      w_term = 1'b0;
      w_prop = 1'b0;
      w_c[0] = cin;
      for (int i = 0; i < SEG_WIDTH; i++) begin
         w_term = w_g[i];
         w_prop = w_p[i];
         for (int j = i - 1; j >= 0; j--) begin
            w_term = w_term | (w_g[j] & w_prop);
            w_prop = w_prop & w_p[j];
         end
         w_c[i+1] = w_term | (w_prop & cin);
      end
   end

   assign s    = w_p ^ w_c[SEG_WIDTH-1:0];
   assign cout = w_c[SEG_WIDTH];

endmodule

// File: rtl/pipelined_adder.sv
// Segmented add/subtract pipeline: one SEG_WIDTH slice per stage, carries registered between
// stages, valid/ready handshake with a global stall.
module pipelined_adder
   import arith_pkg::*;
#(
   parameter int WIDTH     = ADD_WIDTH,
   parameter int SEG_WIDTH = ADD_SEG_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   pipelined_adder_if.slave bus
);
   localparam int NSEG = WIDTH / SEG_WIDTH;
   localparam int NM1  = (NSEG > 1) ? NSEG - 1 : 1;
   localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG_WIDTH{1'b1}});

   generate
      if (!seg_cfg_ok(WIDTH, SEG_WIDTH)) begin : g_bad_cfg
         $error("pipelined_adder: WIDTH must be a non-zero multiple of SEG_WIDTH");
      end
   endgenerate

   logic                 w_stall;
   logic [NSEG-1:0]      r_vld;
   logic [WIDTH-1:0]     r_a [NM1];
   logic [WIDTH-1:0]     r_b [NM1];
   logic [WIDTH-1:0]     r_s [NM1];
   logic                 r_c [NM1];
   logic [WIDTH-1:0]     r_sum;
   logic                 r_cout;
   logic                 r_ovf;

   logic [WIDTH-1:0]     w_a_src [NSEG];
   logic [WIDTH-1:0]     w_b_src [NSEG];
   logic [WIDTH-1:0]     w_s_src [NSEG];
   logic [WIDTH-1:0]     w_s_nxt [NSEG];
   logic                 w_c_src [NSEG];
   logic                 w_cout  [NSEG];
   logic [SEG_WIDTH-1:0] w_seg_s [NSEG];
   logic                 w_ovf;

   assign w_stall      = r_vld[NSEG-1] && !bus.out_ready;
   assign bus.in_ready = !w_stall;

   // Stage k sees unfinished upper segments (skew) and finished lower sums (deskew) from k-1.
   generate
      for (genvar k = 0; k < NSEG; k++) begin : g_stage
         if (k == 0) begin : g_first
            assign w_a_src[k] = bus.a;
            assign w_b_src[k] = bus.b ^ {WIDTH{bus.sub}};
            assign w_s_src[k] = '0;
            assign w_c_src[k] = bus.sub | bus.carry_in;
         end else begin : g_next
            assign w_a_src[k] = r_a[k-1];
            assign w_b_src[k] = r_b[k-1];
            assign w_s_src[k] = r_s[k-1];
            assign w_c_src[k] = r_c[k-1];
         end

         seg_adder #(.SEG_WIDTH(SEG_WIDTH)) u_seg (
            .a    (w_a_src[k][k*SEG_WIDTH +: SEG_WIDTH]),
            .b    (w_b_src[k][k*SEG_WIDTH +: SEG_WIDTH]),
            .cin  (w_c_src[k]),
            .s    (w_seg_s[k]),
            .cout (w_cout[k])
         );

         assign w_s_nxt[k] = (w_s_src[k] & ~(SEG_MASK << (k*SEG_WIDTH)))
                           | (WIDTH'(w_seg_s[k]) << (k*SEG_WIDTH));
      end
   endgenerate

   // Signed overflow judged against the effective (possibly inverted) B operand.
   assign w_ovf = (w_a_src[NSEG-1][WIDTH-1] == w_b_src[NSEG-1][WIDTH-1])
               && (w_s_nxt[NSEG-1][WIDTH-1] != w_a_src[NSEG-1][WIDTH-1]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vld  <= '0;
         r_sum  <= '0;
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
         for (int k = 0; k < NM1; k++) begin
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_s[k] <= '0;
            r_c[k] <= 1'b0;
         end
      end else if (!w_stall) begin
         r_vld[0] <= bus.in_valid;
         for (int k = 1; k < NSEG; k++) r_vld[k] <= r_vld[k-1];
         for (int k = 0; k < NSEG - 1; k++) begin
            r_a[k] <= w_a_src[k];
            r_b[k] <= w_b_src[k];
            r_s[k] <= w_s_nxt[k];
            r_c[k] <= w_cout[k];
         end
         r_sum  <= w_s_nxt[NSEG-1];
         r_cout <= w_cout[NSEG-1];
         r_ovf  <= w_ovf;
      end
   end

   assign bus.out_valid = r_vld[NSEG-1];
   assign bus.sum       = r_sum;
   assign bus.carry_out = r_cout;
   assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: three parameterisations, queue-based reference model, directed vectors.
module tb_pipelined_adder;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          width_of [3] = '{32, 16, 12};

   logic        iv [3];
   logic        cin_d [3];
   logic        sub_d [3];
   logic        ordy [3];
   logic [31:0] a_d [3];
   logic [31:0] b_d [3];
   logic        ov_m [3];
   logic        ir_m [3];
   logic        co_m [3];
   logic        of_m [3];
   logic [31:0] sum_m [3];

   exp_t        q [3][$];
   logic        prev_stall [3];
   logic [31:0] prev_sum [3];

   always #5 clk = ~clk;

   pipelined_adder_if #(.WIDTH(32)) bus0 ();
   pipelined_adder_if #(.WIDTH(16)) bus1 ();
   pipelined_adder_if #(.WIDTH(12)) bus2 ();

   pipelined_adder #(.WIDTH(32), .SEG_WIDTH(8))  dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   pipelined_adder #(.WIDTH(16), .SEG_WIDTH(4))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   pipelined_adder #(.WIDTH(12), .SEG_WIDTH(12)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   assign bus0.in_valid = iv[0];   assign bus0.a = a_d[0];         assign bus0.b = b_d[0];
   assign bus0.carry_in = cin_d[0]; assign bus0.sub = sub_d[0];    assign bus0.out_ready = ordy[0];
   assign bus1.in_valid = iv[1];   assign bus1.a = a_d[1][15:0];   assign bus1.b = b_d[1][15:0];
   assign bus1.carry_in = cin_d[1]; assign bus1.sub = sub_d[1];    assign bus1.out_ready = ordy[1];
   assign bus2.in_valid = iv[2];   assign bus2.a = a_d[2][11:0];   assign bus2.b = b_d[2][11:0];
   assign bus2.carry_in = cin_d[2]; assign bus2.sub = sub_d[2];    assign bus2.out_ready = ordy[2];

   assign ov_m[0] = bus0.out_valid; assign ir_m[0] = bus0.in_ready; assign sum_m[0] = 32'(bus0.sum);
   assign co_m[0] = bus0.carry_out; assign of_m[0] = bus0.overflow;
   assign ov_m[1] = bus1.out_valid; assign ir_m[1] = bus1.in_ready; assign sum_m[1] = 32'(bus1.sum);
   assign co_m[1] = bus1.carry_out; assign of_m[1] = bus1.overflow;
   assign ov_m[2] = bus2.out_valid; assign ir_m[2] = bus2.in_ready; assign sum_m[2] = 32'(bus2.sum);
   assign co_m[2] = bus2.carry_out; assign of_m[2] = bus2.overflow;

   // Reference: whole-word arithmetic in 64 bits, truncated to the instance width.
   function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic cin, logic sub, int w);
      logic [63:0] mask, am, bp, tot;
      exp_t        e;
      mask   = (64'd1 << w) - 64'd1;
      am     = {32'd0, a} & mask;
      bp     = (sub ? ~{32'd0, b} : {32'd0, b}) & mask;
      tot    = am + bp + 64'(sub ? 1'b1 : cin);
      e.sum  = 32'(tot & mask);
      e.cout = tot[w];
      e.ovf  = (am[w-1] == bp[w-1]) && (tot[w-1] != am[w-1]);
      return e;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic mon(int id);
      exp_t e;
      logic stall;
      if (!rst_n) begin
         q[id].delete();
         prev_stall[id] = 1'b0;
         return;
      end
      stall = ov_m[id] && !ordy[id];
      chk($sformatf("in_ready[%0d]", id), 32'(ir_m[id]), 32'(!stall));
      if (prev_stall[id]) begin
         chk($sformatf("hold_valid[%0d]", id), 32'(ov_m[id]), 32'd1);
         chk($sformatf("hold_sum[%0d]", id), sum_m[id], prev_sum[id]);
      end
      if (ov_m[id] && ordy[id]) begin
         if (q[id].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat[%0d]: got sum %0h expected no beat", id, sum_m[id]);
         end else begin
            e = q[id].pop_front();
            chk($sformatf("sum[%0d]", id), sum_m[id], e.sum);
            chk($sformatf("carry_out[%0d]", id), 32'(co_m[id]), 32'(e.cout));
            chk($sformatf("overflow[%0d]", id), 32'(of_m[id]), 32'(e.ovf));
         end
      end
      if (iv[id] && ir_m[id])
         q[id].push_back(model(a_d[id], b_d[id], cin_d[id], sub_d[id], width_of[id]));
      prev_stall[id] = stall;
      prev_sum[id]   = sum_m[id];
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
      mon(2);
   end

   task automatic send(int id, logic [31:0] a, logic [31:0] b, logic cin, logic sub);
      int   n;
      logic ok;
      a_d[id] = a; b_d[id] = b; cin_d[id] = cin; sub_d[id] = sub; iv[id] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         ok = ir_m[id];
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 200);
      iv[id] = 1'b0;
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout[%0d]: got in_ready 0 expected 1 within 200 cycles", id);
      end
   endtask

   // Single beat into an idle pipeline; latency counted in cycles from the accept cycle.
   task automatic dir(int id, string nm, logic [31:0] a, logic [31:0] b, logic cin, logic sub,
                      logic [31:0] es, logic ec, logic eo, int elat);
      int n;
      send(id, a, b, cin, sub);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ov_m[id] && n < 50);
      chk({nm, "_lat"}, 32'(n), 32'(elat));
      chk({nm, "_sum"}, sum_m[id], es);
      chk({nm, "_cout"}, 32'(co_m[id]), 32'(ec));
      chk({nm, "_ovf"}, 32'(of_m[id]), 32'(eo));
      @(posedge clk);
      #1;
   endtask

   task automatic rand_run(int id, int nbeats);
      bit done;
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < nbeats; i++) begin
               if ($urandom_range(3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               send(id, $urandom, $urandom, 1'($urandom), 1'($urandom));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               ordy[id] = ($urandom_range(3) != 0);
            end
            ordy[id] = 1'b1;
         end
      join
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         iv[i] = 1'b0; cin_d[i] = 1'b0; sub_d[i] = 1'b0; ordy[i] = 1'b1;
         a_d[i] = '0; b_d[i] = '0; prev_stall[i] = 1'b0; prev_sum[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", 32'(ov_m[0]), 32'd0);
      chk("rst_sum", sum_m[0], 32'd0);
      chk("rst_cout", 32'(co_m[0]), 32'd0);
      chk("rst_ovf", 32'(of_m[0]), 32'd0);
      chk("rst_in_ready", 32'(ir_m[0]), 32'd1);
      @(posedge clk);
      #1;

      dir(0, "add_wrap",  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 4);
      dir(0, "sub_neg",   32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 4);
      dir(0, "sub_ovf",   32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 4);
      dir(0, "cin_chain", 32'h00FFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h01000000, 1'b0, 1'b0, 4);
      dir(0, "add_ovf",   32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 4);
      dir(0, "sub_cin",   32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0, 4);

      // Back-to-back stream with a 3-cycle downstream stall once the pipe is full
      fork
         begin
            for (int i = 0; i < 8; i++) send(0, $urandom, $urandom, 1'($urandom), 1'($urandom));
         end
         begin
            repeat (5) @(posedge clk);
            #1 ordy[0] = 1'b0;
            repeat (3) @(posedge clk);
            #1 ordy[0] = 1'b1;
         end
      join
      repeat (8) @(posedge clk);
      #1;
      chk("stream_drained", 32'(q[0].size()), 32'd0);

      // Reset with three beats in flight
      for (int i = 0; i < 3; i++) send(0, 32'h11111111 * (i + 1), 32'h00000101, 1'b0, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", 32'(ov_m[0]), 32'd0);
      chk("midrst_sum", sum_m[0], 32'd0);
      chk("midrst_in_ready", 32'(ir_m[0]), 32'd1);
      repeat (6) @(posedge clk);
      #1;
      dir(0, "post_rst", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 4);

      dir(1, "w16_ovf",  32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1, 4);
      dir(1, "w16_sub",  32'h0003, 32'h0005, 1'b0, 1'b1, 32'hFFFE, 1'b0, 1'b0, 4);
      dir(2, "w12_ovf",  32'h7FF,  32'h001,  1'b0, 1'b0, 32'h800,  1'b0, 1'b1, 1);
      dir(2, "w12_wrap", 32'hFFF,  32'h001,  1'b1, 1'b0, 32'h001,  1'b1, 1'b0, 1);

      rand_run(1, 200);
      rand_run(2, 2000);

      repeat (10) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) chk($sformatf("final_drained[%0d]", i), 32'(q[i].size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
